// File: rtl/dk_input_seq.sv
// Donkey Kong player-input front end: PS/2 key latches merged with both joysticks,
// optional horizontal remap, and a coin -> gap -> start sequencer. Outputs active-low.
module dk_input_seq #(
    parameter int TICK_DIV = 24576,
    parameter int COIN_MS  = 50,
    parameter int GAP_MS   = 100,
    parameter int START_MS = 50
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        no_rotate,
    output logic [4:0]  p1_n,
    output logic [4:0]  p2_n,
    output logic        start1_n,
    output logic        start2_n,
    output logic        coin_n
);
    localparam logic [31:0] COIN_LAST  = 32'(COIN_MS * TICK_DIV - 1);
    localparam logic [31:0] GAP_LAST   = 32'(GAP_MS * TICK_DIV - 1);
    localparam logic [31:0] START_LAST = 32'(START_MS * TICK_DIV - 1);

    localparam int K_U = 0, K_D = 1, K_L = 2, K_R = 3, K_J0 = 4, K_J1 = 5;
    localparam int K_S1 = 6, K_F1 = 7, K_S2 = 8, K_F2 = 9, K_C0 = 10, K_C1 = 11;
    localparam int K_P2U = 12, K_P2D = 13, K_P2L = 14, K_P2R = 15, K_P2J = 16;
    localparam int NKEYS = 17;

    typedef enum logic [2:0] {S_IDLE, S_COIN, S_GAP, S_START, S_HOLD} state_t;

    logic             old_toggle_q;
    logic [NKEYS-1:0] keys_q, keys_d;
    logic [15:0]      j;
    logic             req1_q, req1_d, req2_q, req2_d, req_prev_q, req_rise;
    state_t           state_q;
    logic [31:0]      cnt_q;
    logic [1:0]       sel_q;
    logic [4:0]       p1_n_q, p1_n_d, p2_n_q, p2_n_d;
    logic             start1_n_q, start1_n_d, start2_n_q, start2_n_d, coin_n_q, coin_n_d;
    logic             unused_joy;

    // Vectors are {J,R,L,D,U}; rotated cabinet maps up<-left, down<-right, left<-down, right<-up.
    function automatic logic [4:0] remap(input logic [4:0] v, input logic nr);
        return nr ? {v[4], v[0], v[1], v[3], v[2]} : v;
    endfunction

    always_comb begin
        keys_d = keys_q;
        if (ps2_key[10] != old_toggle_q) begin
            case (ps2_key[8:0])
                9'h075, 9'h175: keys_d[K_U]   = ps2_key[9];
                9'h072, 9'h172: keys_d[K_D]   = ps2_key[9];
                9'h06B, 9'h16B: keys_d[K_L]   = ps2_key[9];
                9'h074, 9'h174: keys_d[K_R]   = ps2_key[9];
                9'h029:         keys_d[K_J0]  = ps2_key[9];
                9'h014:         keys_d[K_J1]  = ps2_key[9];
                9'h016:         keys_d[K_S1]  = ps2_key[9];
                9'h005:         keys_d[K_F1]  = ps2_key[9];
                9'h01E:         keys_d[K_S2]  = ps2_key[9];
                9'h006:         keys_d[K_F2]  = ps2_key[9];
                9'h02E:         keys_d[K_C0]  = ps2_key[9];
                9'h036:         keys_d[K_C1]  = ps2_key[9];
                9'h02D:         keys_d[K_P2U] = ps2_key[9];
                9'h02B:         keys_d[K_P2D] = ps2_key[9];
                9'h023:         keys_d[K_P2L] = ps2_key[9];
                9'h034:         keys_d[K_P2R] = ps2_key[9];
                9'h01C:         keys_d[K_P2J] = ps2_key[9];
                default: ;
            endcase
        end
    end

    assign j          = joystick_0 | joystick_1;
    assign unused_joy = ^j[15:8];
    assign req1_d     = keys_q[K_S1] | keys_q[K_F1] | j[5];
    assign req2_d     = keys_q[K_S2] | keys_q[K_F2] | j[6];
    assign req_rise   = (req1_q | req2_q) & ~req_prev_q;

    always_comb begin
        p1_n_d = ~remap({keys_q[K_J0] | keys_q[K_J1] | j[4], keys_q[K_R] | j[0],
                         keys_q[K_L] | j[1], keys_q[K_D] | j[2], keys_q[K_U] | j[3]}, no_rotate);
        p2_n_d = ~remap({keys_q[K_P2J] | j[4], keys_q[K_P2R] | j[0], keys_q[K_P2L] | j[1],
                         keys_q[K_P2D] | j[2], keys_q[K_P2U] | j[3]}, no_rotate);
        coin_n_d   = ~((state_q == S_COIN) | keys_q[K_C0] | keys_q[K_C1] | j[7]);
        start1_n_d = ~((state_q == S_START) & sel_q[0]);
        start2_n_d = ~((state_q == S_START) & sel_q[1]);
    end

    // Toggle and request history keep tracking through reset so a level held across
    // reset release is never mistaken for a new event.
    always_ff @(posedge clk_sys) begin
        old_toggle_q <= ps2_key[10];
        req1_q       <= req1_d;
        req2_q       <= req2_d;
        req_prev_q   <= req1_q | req2_q;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            keys_q     <= '0;
            p1_n_q     <= '1;
            p2_n_q     <= '1;
            start1_n_q <= 1'b1;
            start2_n_q <= 1'b1;
            coin_n_q   <= 1'b1;
        end else begin
            keys_q     <= keys_d;
            p1_n_q     <= p1_n_d;
            p2_n_q     <= p2_n_d;
            start1_n_q <= start1_n_d;
            start2_n_q <= start2_n_d;
            coin_n_q   <= coin_n_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (req_rise) begin
                        sel_q   <= {req2_q, req1_q};
                        state_q <= S_COIN;
                    end
                end
                S_COIN:  if (cnt_q == COIN_LAST)  begin state_q <= S_GAP;   cnt_q <= '0; end
                S_GAP:   if (cnt_q == GAP_LAST)   begin state_q <= S_START; cnt_q <= '0; end
                S_START: if (cnt_q == START_LAST) begin state_q <= S_HOLD;  cnt_q <= '0; end
                S_HOLD: begin
                    cnt_q <= '0;
                    if (!(req1_q | req2_q)) state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign p1_n     = p1_n_q;
    assign p2_n     = p2_n_q;
    assign start1_n = start1_n_q;
    assign start2_n = start2_n_q;
    assign coin_n   = coin_n_q;
endmodule

// File: tb/tb_dk_input_seq.sv
// Directed bench for dk_input_seq: key/joystick/remap vector table plus
// hand-written sequencer, reset and coin-override scenarios (small timing params).
module tb_dk_input_seq;
    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0, joystick_1;
    logic        no_rotate;
    logic [4:0]  p1_n, p2_n;
    logic        start1_n, start2_n, coin_n;

    int ntest = 0;
    int nfail = 0;

    dk_input_seq #(.TICK_DIV(4), .COIN_MS(2), .GAP_MS(3), .START_MS(2)) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1), .no_rotate(no_rotate),
        .p1_n(p1_n), .p2_n(p2_n), .start1_n(start1_n), .start2_n(start2_n), .coin_n(coin_n)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        kv;
        logic [8:0]  code;
        logic        pr;
        logic        nr;
        logic [15:0] j0;
        logic [15:0] j1;
        logic [4:0]  p1;
        logic [4:0]  p2;
        logic        coin;
    } vec_t;

    vec_t vecs[$];

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        ntest++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic key(input logic [8:0] code, input logic pr);
        ps2_key = {~ps2_key[10], pr, code};
    endtask

    task automatic add(input logic kv, input logic [8:0] code, input logic pr, input logic nr,
                       input logic [15:0] j0, input logic [15:0] j1,
                       input logic [4:0] p1, input logic [4:0] p2, input logic coin);
        vec_t v;
        v.kv = kv; v.code = code; v.pr = pr; v.nr = nr; v.j0 = j0; v.j1 = j1;
        v.p1 = p1; v.p2 = p2; v.coin = coin;
        vecs.push_back(v);
    endtask

    // Follows one coin/gap/start sequence and checks phase lengths and which start fired.
    task automatic measure(input string nm, input bit e1, input bit e2);
        int t, cl, gl, sl;
        bit s1, s2;
        t = 0;
        while (coin_n && t < 20) begin t++; step(1); end
        chk({nm, " coin seen"}, coin_n, 0);
        cl = 0;
        while (!coin_n && cl < 40) begin cl++; step(1); end
        gl = 0;
        while (coin_n && start1_n && start2_n && gl < 40) begin gl++; step(1); end
        sl = 0; s1 = 0; s2 = 0;
        while ((!start1_n || !start2_n) && sl < 40) begin
            s1 |= !start1_n; s2 |= !start2_n; sl++; step(1);
        end
        chk({nm, " coin len"}, cl, 8);
        chk({nm, " gap len"}, gl, 12);
        chk({nm, " start len"}, sl, 8);
        chk({nm, " start1 used"}, int'(s1), int'(e1));
        chk({nm, " start2 used"}, int'(s2), int'(e2));
    endtask

    task automatic count_coin(input string nm, input int n);
        int lows = 0;
        for (int i = 0; i < n; i++) begin step(1); if (!coin_n) lows++; end
        chk({nm, " no coin"}, lows, 0);
    endtask

    initial begin
        int g, t;
        reset = 1'b1; ps2_key = {1'b1, 1'b1, 9'h075};
        joystick_0 = '0; joystick_1 = '0; no_rotate = 1'b0;
        step(3);
        chk("reset p1", p1_n, 5'h1F);
        chk("reset p2", p2_n, 5'h1F);
        chk("reset coin", coin_n, 1);
        chk("reset start1", start1_n, 1);
        chk("reset start2", start2_n, 1);
        reset = 1'b0;
        step(4);
        chk("no spurious key p1", p1_n, 5'h1F);

        add(1, 9'h075, 1, 0, 16'h0000, 16'h0000, 5'h1E, 5'h1F, 1);
        add(1, 9'h075, 0, 0, 16'h0000, 16'h0000, 5'h1F, 5'h1F, 1);
        add(1, 9'h172, 1, 0, 16'h0000, 16'h0000, 5'h1D, 5'h1F, 1);
        add(1, 9'h172, 0, 0, 16'h0000, 16'h0000, 5'h1F, 5'h1F, 1);
        add(1, 9'h029, 1, 0, 16'h0000, 16'h0000, 5'h0F, 5'h1F, 1);
        add(1, 9'h029, 0, 0, 16'h0000, 16'h0000, 5'h1F, 5'h1F, 1);
        add(1, 9'h014, 1, 0, 16'h0000, 16'h0000, 5'h0F, 5'h1F, 1);
        add(1, 9'h014, 0, 0, 16'h0000, 16'h0000, 5'h1F, 5'h1F, 1);
        add(1, 9'h02D, 1, 0, 16'h0000, 16'h0000, 5'h1F, 5'h1E, 1);
        add(1, 9'h02D, 0, 0, 16'h0000, 16'h0000, 5'h1F, 5'h1F, 1);
        add(1, 9'h01C, 1, 0, 16'h0000, 16'h0000, 5'h1F, 5'h0F, 1);
        add(1, 9'h01C, 0, 0, 16'h0000, 16'h0000, 5'h1F, 5'h1F, 1);
        add(0, 9'h000, 0, 0, 16'h0010, 16'h0000, 5'h0F, 5'h0F, 1);
        add(0, 9'h000, 0, 1, 16'h0002, 16'h0000, 5'h1E, 5'h1E, 1);
        add(0, 9'h000, 0, 1, 16'h0002, 16'h0008, 5'h16, 5'h16, 1);
        add(0, 9'h000, 0, 1, 16'h0000, 16'h0001, 5'h1D, 5'h1D, 1);
        add(0, 9'h000, 0, 1, 16'h0004, 16'h0000, 5'h1B, 5'h1B, 1);
        add(0, 9'h000, 0, 0, 16'h0004, 16'h0000, 5'h1D, 5'h1D, 1);
        add(0, 9'h000, 0, 0, 16'h0080, 16'h0000, 5'h1F, 5'h1F, 0);
        add(1, 9'h036, 1, 0, 16'h0000, 16'h0000, 5'h1F, 5'h1F, 0);
        add(1, 9'h036, 0, 0, 16'h0000, 16'h0000, 5'h1F, 5'h1F, 1);
        add(1, 9'h01A, 1, 0, 16'h0000, 16'h0000, 5'h1F, 5'h1F, 1);
        add(1, 9'h06B, 1, 1, 16'h0000, 16'h0000, 5'h1E, 5'h1F, 1);
        add(1, 9'h06B, 0, 0, 16'h0000, 16'h0000, 5'h1F, 5'h1F, 1);

        foreach (vecs[i]) begin
            if (vecs[i].kv) key(vecs[i].code, vecs[i].pr);
            no_rotate = vecs[i].nr; joystick_0 = vecs[i].j0; joystick_1 = vecs[i].j1;
            step(2);
            chk($sformatf("vec%0d p1", i), p1_n, vecs[i].p1);
            chk($sformatf("vec%0d p2", i), p2_n, vecs[i].p2);
            chk($sformatf("vec%0d coin", i), coin_n, vecs[i].coin);
        end

        // Latency: key lands on the second edge, joystick on the first.
        key(9'h074, 1);
        step(1); chk("key lat edge1", p1_n, 5'h1F);
        step(1); chk("key lat edge2", p1_n, 5'h17);
        key(9'h074, 0); step(2);
        joystick_0 = 16'h0001;
        step(1); chk("joy lat edge1", p1_n, 5'h17);
        joystick_0 = 16'h0000; step(2);

        // Single joystick start pulse.
        joystick_0[5] = 1'b1; step(1); joystick_0[5] = 1'b0;
        measure("pulse", 1, 0);
        step(4);

        // F2 held, F1 added during the gap: one sequence, start2 only.
        key(9'h006, 1);
        fork
            measure("f2", 0, 1);
            begin step(15); key(9'h005, 1); end
        join
        key(9'h006, 0);
        count_coin("hold f1", 30);
        key(9'h005, 0); step(4);
        key(9'h005, 1);
        measure("f1 again", 1, 0);
        key(9'h005, 0); step(4);

        // Reset during START with the request held.
        joystick_0[5] = 1'b1;
        t = 0;
        while (start1_n && t < 60) begin t++; step(1); end
        chk("reached start", start1_n, 0);
        reset = 1'b1; step(1);
        chk("rst start1", start1_n, 1);
        chk("rst start2", start2_n, 1);
        chk("rst coin", coin_n, 1);
        step(1); reset = 1'b0;
        count_coin("held after rst", 40);
        joystick_0[5] = 1'b0; step(3);
        joystick_0[5] = 1'b1; step(1); joystick_0[5] = 1'b0;
        measure("repress", 1, 0);
        step(4);

        // Coin key during the gap forces coin without moving the sequencer.
        joystick_0[5] = 1'b1; step(1); joystick_0[5] = 1'b0;
        t = 0;
        while (coin_n && t < 20) begin t++; step(1); end
        t = 0;
        while (!coin_n && t < 40) begin t++; step(1); end
        chk("coin phase len", t, 8);
        g = 0;
        while (start1_n && g < 40) begin
            if (g == 3) key(9'h02E, 1);
            if (g == 5) chk("coin key in gap", coin_n, 0);
            if (g == 6) key(9'h02E, 0);
            g++; step(1);
        end
        chk("gap len with coin key", g, 12);
        step(12);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
